// File: rtl/reset_sequencer_lsb.sv
// Priority encoder: reports whether any request bit is set and the index of the lowest one.
// Purely combinational, zero latency.
// No flow control; the result follows the request vector directly.
module lowest_set_bit #(
    parameter  int W  = 4,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          vld,
    output logic [IW-1:0] idx
);

    always_comb begin
        vld = |req;
        idx = '0;
        // Scan from the top down so the lowest set bit is written last and wins.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases STAGES reset domains in order, holding each for LENGTH cycles and waiting for its ready.
// Latency: first release LENGTH edges after reset_in drops; each later release comes at least LENGTH+1 edges after the previous one.
// No backpressure: restart_req is a level sampled every edge, and a timeout bounds every wait on ready.
module reset_sequencer #(
    parameter  int STAGES  = 4,
    parameter  int LENGTH  = 7,
    parameter  int TIMEOUT = 255,
    localparam int SW      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic [STAGES-1:0] restart_req,
    input  logic [STAGES-1:0] ready,
    output logic [STAGES-1:0] reset_out,
    output logic              busy,
    output logic              fault,
    output logic [SW-1:0]     fault_stage
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int MAXV = (LENGTH > TIMEOUT) ? LENGTH : TIMEOUT;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [CW-1:0] LEN_LAST   = CW'(LENGTH - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

    state_t              state_q, state_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [STAGES-1:0]   rst_d;
    logic                busy_d;
    logic                fault_d;
    logic [SW-1:0]       fstage_d;
    logic                advance;

    logic                rr_vld;
    logic [SW-1:0]       rr_idx;

    lowest_set_bit #(
        .W (STAGES)
    ) u_restart_pick (
        .req (restart_req),
        .vld (rr_vld),
        .idx (rr_idx)
    );

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_HOLD;
            stage_q     <= '0;
            cnt_q       <= '0;
            reset_out   <= '1;
            busy        <= 1'b1;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            reset_out   <= rst_d;
            busy        <= busy_d;
            fault       <= fault_d;
            fault_stage <= fstage_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        rst_d    = reset_out;
        busy_d   = busy;
        fault_d  = fault;
        fstage_d = fault_stage;
        advance  = 1'b0;

        // A restart aimed above the current stage is dropped: those domains are still held anyway.
        if (rr_vld && (state_q == ST_DONE || rr_idx <= stage_q)) begin
            for (int j = 0; j < STAGES; j++) begin
                if (j >= int'(rr_idx)) rst_d[j] = 1'b1;
            end
            stage_d = rr_idx;
            cnt_d   = '0;
            state_d = ST_HOLD;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == LEN_LAST) begin
                        rst_d[stage_q] = 1'b0;
                        cnt_d          = '0;
                        state_d        = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (TIMEOUT == 0 || ready[stage_q]) begin
                        advance = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        fault_d  = 1'b1;
                        fstage_d = stage_q;
                        advance  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase

            if (advance) begin
                cnt_d = '0;
                if (stage_q == LAST_STAGE) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    stage_d = stage_q + SW'(1);
                    state_d = ST_HOLD;
                end
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGES=3, LENGTH=7, TIMEOUT=15.
// Edges are counted from the first rising edge after reset_in drops; outputs are sampled 1 time unit after each edge.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_in;
    logic [2:0] restart_req;
    logic [2:0] ready;
    logic [2:0] reset_out;
    logic       busy;
    logic       fault;
    logic [1:0] fault_stage;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    int r;

    always #5 clk = ~clk;

    reset_sequencer #(
        .STAGES  (3),
        .LENGTH  (7),
        .TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .restart_req (restart_req),
        .ready       (ready),
        .reset_out   (reset_out),
        .busy        (busy),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic release_reset();
        reset_in    = 1'b1;
        restart_req = 3'b000;
        @(negedge clk);
        reset_in = 1'b0;
        edge_n   = 0;
    endtask

    task automatic pulse(input logic [2:0] req);
        restart_req = req;
        tick();
        restart_req = 3'b000;
    endtask

    initial begin
        reset_in    = 1'b1;
        restart_req = 3'b000;
        ready       = 3'b111;
        #2;
        check("rst_reset_out", 32'(reset_out), 32'h7);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_stage", 32'(fault_stage), 32'h0);

        // Power-up with all domains ready.
        release_reset();
        for (int e = 1; e <= 24; e++) begin
            tick();
            check($sformatf("pwr_reset_out_e%0d", e), 32'(reset_out),
                  (e < 7) ? 32'h7 : (e < 15) ? 32'h6 : (e < 23) ? 32'h4 : 32'h0);
            check($sformatf("pwr_busy_e%0d", e), 32'(busy), (e < 24) ? 32'h1 : 32'h0);
        end
        check("pwr_fault", 32'(fault), 32'h0);

        // Domain 1 never comes up: timeout after 15 wait edges.
        ready = 3'b101;
        release_reset();
        run_to(14);
        check("to_reset_out_e14", 32'(reset_out), 32'h6);
        tick();
        check("to_reset_out_e15", 32'(reset_out), 32'h4);
        run_to(29);
        check("to_fault_e29", 32'(fault), 32'h0);
        tick();
        check("to_fault_e30", 32'(fault), 32'h1);
        check("to_fault_stage_e30", 32'(fault_stage), 32'h1);
        check("to_reset_out_e30", 32'(reset_out), 32'h4);
        run_to(36);
        check("to_reset_out_e36", 32'(reset_out), 32'h4);
        tick();
        check("to_reset_out_e37", 32'(reset_out), 32'h0);
        check("to_busy_e37", 32'(busy), 32'h1);
        tick();
        check("to_busy_e38", 32'(busy), 32'h0);

        // Restart from stage 1 after DONE; fault must survive.
        ready = 3'b111;
        pulse(3'b010);
        r = edge_n;
        check("rs1_reset_out", 32'(reset_out), 32'h6);
        check("rs1_busy", 32'(busy), 32'h1);
        check("rs1_fault", 32'(fault), 32'h1);
        run_to(r + 6);
        check("rs1_reset_out_r6", 32'(reset_out), 32'h6);
        tick();
        check("rs1_reset_out_r7", 32'(reset_out), 32'h4);
        run_to(r + 14);
        check("rs1_reset_out_r14", 32'(reset_out), 32'h4);
        tick();
        check("rs1_reset_out_r15", 32'(reset_out), 32'h0);
        tick();
        check("rs1_busy_r16", 32'(busy), 32'h0);
        check("rs1_fault_kept", 32'(fault), 32'h1);
        check("rs1_fault_stage_kept", 32'(fault_stage), 32'h1);

        // Mid-sequence restart with 101: lowest bit wins, full sequence repeats.
        release_reset();
        run_to(18);
        check("rs0_reset_out_e18", 32'(reset_out), 32'h4);
        pulse(3'b101);
        r = edge_n;
        check("rs0_reset_out", 32'(reset_out), 32'h7);
        run_to(r + 6);
        check("rs0_reset_out_r6", 32'(reset_out), 32'h7);
        tick();
        check("rs0_reset_out_r7", 32'(reset_out), 32'h6);
        run_to(r + 15);
        check("rs0_reset_out_r15", 32'(reset_out), 32'h4);
        run_to(r + 23);
        check("rs0_reset_out_r23", 32'(reset_out), 32'h0);
        check("rs0_busy_r23", 32'(busy), 32'h1);
        tick();
        check("rs0_busy_r24", 32'(busy), 32'h0);

        // Asynchronous reset during stage-1 wait with fault set.
        ready = 3'b101;
        release_reset();
        run_to(30);
        check("ar_fault_e30", 32'(fault), 32'h1);
        pulse(3'b010);
        check("ar_reset_out_e31", 32'(reset_out), 32'h6);
        run_to(38);
        check("ar_reset_out_e38", 32'(reset_out), 32'h4);
        run_to(40);
        #3;
        reset_in = 1'b1;
        #1;
        check("ar_reset_out", 32'(reset_out), 32'h7);
        check("ar_fault", 32'(fault), 32'h0);
        check("ar_fault_stage", 32'(fault_stage), 32'h0);
        check("ar_busy", 32'(busy), 32'h1);
        ready = 3'b111;
        release_reset();
        run_to(6);
        check("ar_reset_out_e6", 32'(reset_out), 32'h7);
        tick();
        check("ar_reset_out_e7", 32'(reset_out), 32'h6);

        // Restart and ready arrive at the same edge: restart wins.
        ready = 3'b001;
        release_reset();
        run_to(16);
        check("pr_reset_out_e16", 32'(reset_out), 32'h4);
        ready = 3'b111;
        pulse(3'b010);
        r = edge_n;
        check("pr_reset_out_e17", 32'(reset_out), 32'h6);
        run_to(r + 6);
        check("pr_reset_out_r6", 32'(reset_out), 32'h6);
        tick();
        check("pr_reset_out_r7", 32'(reset_out), 32'h4);
        check("pr_fault", 32'(fault), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
